defunnel_buffered: RTL
======================

# defunnel_buffered

Widening stage that sits directly downstream of the buffered funnel and reverses it. It accepts a stream of `dataWidth`-bit words on a PipeIn-style handshake and packs each run of `funnelWidth` consecutive words into one `funnelWidth*dataWidth`-bit beat. Completed beats are presented through a one-entry holding buffer. Input words keep flowing while a completed beat waits for the consumer.

## Interface

Parameters:
- `dataWidth`, default 32: width of one narrow input word.
- `funnelWidth`, default 4: words per wide beat; must be at least 2.

Ports:
- `CLK`, input, 1: single clock; everything is rising-edge.
- `RST`, input, 1: reset, asynchronous and active-high.
- `in$enq__ENA`, input, 1: input word transfer this cycle.
- `in$enq$v`, input, `dataWidth`: input word.
- `in$enq__RDY`, output, 1: block can take a word this cycle.
- `out$enq__ENA`, output, 1: wide-beat transfer this cycle.
- `out$enq$v`, output, `funnelWidth*dataWidth`: wide beat.
- `out$enq__RDY`, input, 1: consumer can take a beat this cycle.

## Operation

- **Handshake rule (both sides):** a transfer happens in any cycle where ENA=1. ENA may be asserted only while RDY=1. The block asserts nothing on the input for ENA with RDY=0; that is a protocol violation.
- **State:**
  - `lane` counter, width clog2(`funnelWidth`).
  - Accumulator `acc[funnelWidth-1:0][dataWidth-1:0]`.
  - Holding register `hold` with `full` flag.
- **Lane order:** the first word of a beat goes to lane 0, the least-significant `dataWidth` bits of `out$enq$v`. The word for lane k lands at bits [k*dataWidth +: dataWidth]. This matches the funnel, which emits lane 0 first.
- **Input accept, `lane` < `funnelWidth`-1:** write `acc[lane]`, then increment `lane`.
- **Input accept, `lane` == `funnelWidth`-1:**
  - `hold` ← {incoming word, `acc[funnelWidth-2:0]`}.
  - `full` ← 1.
  - `lane` ← 0.
- **`in$enq__RDY`** = (`lane` != `funnelWidth`-1) | !`full` | `out$enq__RDY`. Only the closing word is stalled, and only when `hold` is occupied and not draining this cycle.
- **`out$enq__ENA`** = `full` & `out$enq__RDY`.
- **`out$enq$v`** = `hold`, driven continuously.
- **Drain:** on an out transfer, `full` ← 0, unless a closing word is accepted in the same cycle. In that case `full` stays 1 and `hold` takes the new beat.
- **Stale data:** `acc` lanes are overwritten, never cleared. Stale lanes are never observable because a beat is only built from a full run.

## Timing

- **Reset values (asynchronous while `RST`=1):**
  - `lane`=0, `full`=0, `acc`=0, `hold`=0.
  - Outputs: `out$enq__ENA`=0, `out$enq$v`=0, `in$enq__RDY`=1.
- **Latency:** closing word accepted at cycle N → `out$enq__ENA` can be 1 at cycle N+1.
- **Throughput:** one word per cycle sustained with `out$enq__RDY` held at 1. One beat every `funnelWidth` cycles, with no bubbles.
- **Combinational paths:** `out$enq__RDY` → `in$enq__RDY` is combinational and permitted. There is no path from `in$enq__ENA` to any output.
- **Reset mid-beat:** the partial beat is discarded, and so is any beat held in `hold`. The first word after reset goes to lane 0.
- **`funnelWidth`=2:** the counter is 1 bit wide; the same rules apply.

## Structure

- **Shared package `funnel_pkg`:**
  - Function `lane_bits(funnelWidth)` returning the clog2 width (minimum 1).
  - Typedef of the wide-beat vector, shared with the funnel so both stages agree on lane order.
- **Sub-module `pipe_buffer1`:** the one-entry holding register with `full` flag. It has enq/deq handshakes, supports simultaneous deq+enq, and is parameterised by width.
- The packing counter and accumulator stay in the top module.

## Test plan

- **Basic pack:** reset, `out$enq__RDY`=1, feed 0x11,0x22,0x33,0x44 on consecutive cycles → one beat 0x00000044_00000033_00000022_00000011, with `out$enq__ENA` the cycle after 0x44.
- **Back-pressure:** `out$enq__RDY`=0, feed 8 words → `in$enq__RDY` falls only when `lane`=3 with `full`=1. Raising RDY drains beat 1, then accepts the 8th word in the same cycle; beat 2 follows.
- **Streaming:** 400 consecutive words, `out$enq__RDY`=1 → 100 beats, exactly 4 cycles apart, with no input stall.
- **Random:** randomized ENA/RDY gaps (each 30% idle), 1000 words → the output equals the reference packing model, in order, with no loss or duplication.
- **Reset mid-beat:** feed 2 words, pulse `RST` asynchronously between clock edges → `out$enq__ENA`=0 immediately. The next 4 words form one clean beat.
- **`funnelWidth`=2, `dataWidth`=8:** 0xAB,0xCD → beat 0xCDAB.

Source files
------------

// File: rtl/funnel_pkg.sv
// Shared definitions for the funnel / defunnel pair: lane counter sizing
// and the wide-beat layout both stages agree on.
package funnel_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_FUNNEL_WIDTH = 4;

    // Wide beat as lanes of narrow words; lane 0 occupies the least-significant
    // slice, so lane k sits at bits [k*dataWidth +: dataWidth].
    typedef logic [DEFAULT_FUNNEL_WIDTH-1:0][DEFAULT_DATA_WIDTH-1:0] beat_t;

    // Width of a counter that indexes funnel_width lanes (never below 1 bit).
    function automatic int lane_bits(input int funnel_width);
        int w;
        w = $clog2(funnel_width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/defunnel_buffered_if.sv
// Enq-style handshake: a transfer happens in any cycle where enq__ENA=1,
// and the master may only raise enq__ENA while enq__RDY=1.
interface defunnel_buffered_if #(
    parameter int W = 32
);
    logic         enq__ENA;
    logic [W-1:0] enq_v;
    logic         enq__RDY;

    modport master (output enq__ENA, output enq_v, input  enq__RDY);
    modport slave  (input  enq__ENA, input  enq_v, output enq__RDY);
endinterface

// File: rtl/pipe_buffer1.sv
// One-entry holding register with a full flag. A dequeue and an enqueue in
// the same cycle replace the entry and leave it full.
module pipe_buffer1 #(
    parameter int width = 128
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enq_ena,
    input  logic [width-1:0] enq_v,
    output logic             enq_rdy,
    input  logic             deq_ena,
    output logic             full,
    output logic [width-1:0] data
);
    logic             full_q, full_d;
    logic [width-1:0] data_q, data_d;

    // Room for a new entry when empty, or when the current one leaves this cycle.
    assign enq_rdy = !full_q | deq_ena;
    assign full    = full_q;
    assign data    = data_q;

    // Next-state for the flag and the stored entry.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
        full_d = full_q;
        data_d = data_q;
        if (enq_ena) begin
            full_d = 1'b1;
            data_d = enq_v;
        end else if (deq_ena) begin
            full_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/defunnel_buffered.sv
// Defunnel: packs runs of funnelWidth narrow words (lane 0 first) into one
// wide beat, presented through a one-entry holding buffer so the input keeps
// flowing while a completed beat waits for the consumer.
module defunnel_buffered
    import funnel_pkg::*;
#(
    parameter int dataWidth   = 32,
    parameter int funnelWidth = 4
) (
    input logic                 CLK,
    input logic                 RST,
    defunnel_buffered_if.slave  in,
    defunnel_buffered_if.master out
);
    localparam int               LaneW    = lane_bits(funnelWidth);
    localparam int               BeatW    = funnelWidth * dataWidth;
    localparam logic [LaneW-1:0] LastLane = LaneW'(funnelWidth - 1);

    logic [LaneW-1:0] lane_q, lane_d;
    // The top lane never needs storage: the closing word goes straight into
    // the holding buffer alongside the lower lanes.
    logic [funnelWidth-2:0][dataWidth-1:0] acc_q, acc_d;

    logic             at_last;
    logic             close_beat;
    logic             drain;
    logic             hold_rdy;
    logic             full;
    logic [BeatW-1:0] beat;
    logic [BeatW-1:0] hold;

    assign at_last    = (lane_q == LastLane);
    assign close_beat = in.enq__ENA & at_last;
    assign drain      = full & out.enq__RDY;
    assign beat       = {in.enq_v, acc_q};

    // Only the closing word can stall, and only if the held beat cannot leave.
    assign in.enq__RDY  = !at_last | hold_rdy;
    assign out.enq__ENA = drain;
    assign out.enq_v    = hold;

    pipe_buffer1 #(
        .width (BeatW)
    ) u_hold (
        .CLK     (CLK),
        .RST     (RST),
        .enq_ena (close_beat),
        .enq_v   (beat),
        .enq_rdy (hold_rdy),
        .deq_ena (drain),
        .full    (full),
        .data    (hold)
    );

    // Lane counter advance and accumulator write for non-closing words.
    always_comb begin
        lane_d = lane_q;
        acc_d  = acc_q;
        if (in.enq__ENA) begin
            if (at_last) begin
                lane_d = '0;
            end else begin
                lane_d = lane_q + 1'b1;
                for (int k = 0; k < funnelWidth - 1; k++) begin
                    if (lane_q == LaneW'(k)) begin
                        acc_d[k] = in.enq_v;
                    end
                end
            end
        end
    end

    // Packing state registers; a reset discards any partial beat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane_q <= '0;
            // NOTE: the accumulator is cleared here only because its reset value is defined;
            // stale lanes are never observable, so a plain storage array could skip the reset.
            acc_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end
endmodule
